// File: rtl/gf2m_pkg.sv
// Shared definitions for the GF(2^m) digit-serial multiplier: field constants,
// FSM encoding and the multiply-by-x reduction step.
package gf2m_pkg;

    localparam int M_B163 = 163;
    localparam logic [M_B163-1:0] POLY_B163 = 163'hC9;

    // Widest field the mulx helper supports (covers the NIST B-571 curve).
    localparam int MAX_M = 571;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // One step of A <- A*x mod f(x), evaluated on the low m bits of a MAX_M-wide
    // vector. Bits at position m and above are always returned as zero.
    function automatic logic [MAX_M-1:0] mulx(
        input logic [MAX_M-1:0] a,
        input logic [MAX_M-1:0] poly,
        input logic [9:0]       m
    );
        logic [MAX_M-1:0] mask;
        logic [MAX_M-1:0] r;
        mask = {MAX_M{1'b1}} >> (MAX_M - m);
        r    = (a << 1) & mask;
        if (a[m - 10'd1]) begin
            r = r ^ (poly & mask);
        end
        return r;
    endfunction

endpackage

// File: rtl/gf2m_digit_step.sv
// Combinational digit step: folds D bits of B into the accumulator C, advancing
// A by one multiply-by-x per bit.
module gf2m_digit_step
    import gf2m_pkg::*;
#(
    parameter int            M    = M_B163,
    parameter logic [M-1:0]  POLY = M'(POLY_B163),
    parameter int            D    = 4
) (
    input  logic [M-1:0] a_cur,
    input  logic [M-1:0] c_cur,
    input  logic [D-1:0] digit,
    output logic [M-1:0] a_next,
    output logic [M-1:0] c_next
);

    // NOTE: blocking assignments here are deliberate; each unrolled iteration
    // must see the A and C produced by the previous one within the same cycle.
    always_comb begin
        a_next = a_cur;
        c_next = c_cur;
        for (int j = 0; j < D; j++) begin
            if (digit[j]) begin
                c_next = c_next ^ a_next;
            end
            a_next = M'(mulx(MAX_M'(a_next), MAX_M'(POLY), 10'(M)));
        end
    end

endmodule

// File: rtl/gf2m_digit_mult.sv
// Digit-serial LSB-first GF(2^M) multiplier with valid/ready handshakes on both
// sides; consumes D bits of B per cycle, result after ceil(M/D) cycles.
module gf2m_digit_mult
    import gf2m_pkg::*;
#(
    parameter int            M    = M_B163,
    parameter logic [M-1:0]  POLY = M'(POLY_B163),
    parameter int            D    = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    input  logic         sq,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] z,
    output logic         busy
);

    localparam int N     = (M + D - 1) / D;
    localparam int CNT_W = $clog2(N + 1);

    state_t           state;
    state_t           state_nxt;
    logic [M-1:0]     reg_a;
    logic [M-1:0]     reg_b;
    logic [M-1:0]     reg_c;
    logic [M-1:0]     a_step;
    logic [M-1:0]     c_step;
    logic [CNT_W-1:0] cnt;
    logic             last;

    gf2m_digit_step #(
        .M    (M),
        .POLY (POLY),
        .D    (D)
    ) u_step (
        .a_cur  (reg_a),
        .c_cur  (reg_c),
        .digit  (reg_b[D-1:0]),
        .a_next (a_step),
        .c_next (c_step)
    );

    assign last = (cnt == CNT_W'(N - 1));
    assign z    = reg_c;

    // NOTE: every output of this block gets a default first so no path through
    // the case statement leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            reg_a <= '0;
            reg_b <= '0;
            reg_c <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                reg_a <= a;
                reg_b <= sq ? a : b;
                reg_c <= '0;
                cnt   <= '0;
            end else if (state == CALC) begin
                // Shifting right leaves zeros above M-1 for the final partial digit.
                reg_a <= a_step;
                reg_c <= c_step;
                reg_b <= reg_b >> D;
                cnt   <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gf2m_digit_mult.sv
// Self-checking bench for gf2m_digit_mult: five instances with D = 4, 1, 7, 8, 163
// compared against a schoolbook multiply-then-reduce reference model.
module tb_gf2m_digit_mult;

    localparam int M = 163;
    localparam int NS [5] = '{41, 163, 24, 21, 1};

    logic         clk = 1'b0;
    logic         rst;
    logic [4:0]   in_valid;
    logic [4:0]   out_ready;
    logic [4:0]   in_ready;
    logic [4:0]   out_valid;
    logic [4:0]   busy;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic         sq;
    logic [M-1:0] z [5];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    gf2m_digit_mult #(.M(M), .POLY(163'hC9), .D(4)) dut_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .sq(sq), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .z(z[0]), .busy(busy[0]));
    gf2m_digit_mult #(.M(M), .POLY(163'hC9), .D(1)) dut_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .sq(sq), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .z(z[1]), .busy(busy[1]));
    gf2m_digit_mult #(.M(M), .POLY(163'hC9), .D(7)) dut_d7 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .sq(sq), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .z(z[2]), .busy(busy[2]));
    gf2m_digit_mult #(.M(M), .POLY(163'hC9), .D(8)) dut_d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a), .b(b), .sq(sq), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .z(z[3]), .busy(busy[3]));
    gf2m_digit_mult #(.M(M), .POLY(163'hC9), .D(163)) dut_d163 (
        .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_ready(in_ready[4]),
        .a(a), .b(b), .sq(sq), .out_valid(out_valid[4]), .out_ready(out_ready[4]),
        .z(z[4]), .busy(busy[4]));

    // Reference: full carry-less product, then reduce from the top bit down.
    function automatic logic [M-1:0] ref_mul(input logic [M-1:0] av, input logic [M-1:0] bv);
        logic [2*M-1:0] p;
        logic [2*M-1:0] f;
        p = '0;
        f = '0;
        f[M] = 1'b1;
        f[M-1:0] = 163'hC9;
        for (int i = 0; i < M; i++)
            if (bv[i]) p = p ^ ({{M{1'b0}}, av} << i);
        for (int i = 2*M-2; i >= M; i--)
            if (p[i]) p = p ^ (f << (i - M));
        return p[M-1:0];
    endfunction

    function automatic logic [M-1:0] rand163();
        logic [191:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return t[M-1:0];
    endfunction

    // Issue one operation to instance k (which must be idle) and wait for out_valid.
    task automatic do_op(input int k, input logic [M-1:0] av, input logic [M-1:0] bv,
                         input logic sv, output logic [M-1:0] zv, output int lat);
        @(negedge clk);
        a = av;
        b = bv;
        sq = sv;
        in_valid[k] = 1'b1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        zv = z[k];
    endtask

    task automatic release_out(input int k);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        a = '0;
        b = '0;
        sq = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks += 4;
            if (in_ready[k] !== 1'b1) begin
                fails++; $display("FAIL reset_in_ready[%0d]: got %b want 1", k, in_ready[k]);
            end
            if (out_valid[k] !== 1'b0) begin
                fails++; $display("FAIL reset_out_valid[%0d]: got %b want 0", k, out_valid[k]);
            end
            if (busy[k] !== 1'b0) begin
                fails++; $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]);
            end
            if (z[k] !== '0) begin
                fails++; $display("FAIL reset_z[%0d]: got %h want 0", k, z[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        logic [M-1:0] zv;
        int lat;
        out_ready[0] = 1'b1;  // ready before valid must not disturb anything
        do_op(0, 163'd1, 163'd1, 1'b0, zv, lat);
        checks += 2;
        if (zv !== 163'd1) begin
            fails++; $display("FAIL identity_z: got %h want 1", zv);
        end
        if (lat != 41) begin
            fails++; $display("FAIL identity_latency: got %0d want 41", lat);
        end
        release_out(0);
    endtask

    task automatic test_reduction();
        logic [M-1:0] zv;
        logic [M-1:0] x162;
        int lat;
        x162 = '0;
        x162[162] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            do_op(k, x162, 163'd2, 1'b0, zv, lat);
            checks += 2;
            if (zv !== 163'hC9) begin
                fails++; $display("FAIL reduction_z[%0d]: got %h want c9", k, zv);
            end
            if (lat != NS[k]) begin
                fails++; $display("FAIL reduction_latency[%0d]: got %0d want %0d", k, lat, NS[k]);
            end
            release_out(k);
        end
    endtask

    task automatic test_small_and_square();
        logic [M-1:0] zv;
        logic [M-1:0] av;
        int lat;
        do_op(0, 163'd3, 163'd3, 1'b0, zv, lat);
        checks++;
        if (zv !== 163'd5) begin
            fails++; $display("FAIL small_z: got %h want 5", zv);
        end
        release_out(0);
        do_op(0, 163'd3, rand163(), 1'b1, zv, lat);
        checks++;
        if (zv !== 163'd5) begin
            fails++; $display("FAIL square_small_z: got %h want 5", zv);
        end
        release_out(0);
        for (int i = 0; i < 4; i++) begin
            av = rand163();
            do_op(3, av, rand163(), 1'b1, zv, lat);
            checks++;
            if (zv !== ref_mul(av, av)) begin
                fails++; $display("FAIL square_rand_z[%0d]: got %h want %h", i, zv, ref_mul(av, av));
            end
            release_out(3);
        end
        sq = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [M-1:0] zv;
        logic [M-1:0] av;
        logic [M-1:0] bv;
        logic [M-1:0] expz;
        int lat;
        do_op(0, rand163(), 163'd0, 1'b0, zv, lat);
        checks++;
        if (zv !== '0) begin
            fails++; $display("FAIL zero_z: got %h want 0", zv);
        end
        release_out(0);

        av = rand163();
        bv = rand163();
        expz = ref_mul(av, bv);
        do_op(0, av, bv, 1'b0, zv, lat);
        for (int i = 0; i < 20; i++) begin
            // Fresh operands and toggling in_valid while DONE must not be taken.
            a = rand163();
            b = rand163();
            in_valid[0] = ~in_valid[0];
            @(negedge clk);
            checks += 4;
            if (out_valid[0] !== 1'b1) begin
                fails++; $display("FAIL hold_out_valid[%0d]: got %b want 1", i, out_valid[0]);
            end
            if (z[0] !== expz) begin
                fails++; $display("FAIL hold_z[%0d]: got %h want %h", i, z[0], expz);
            end
            if (in_ready[0] !== 1'b0) begin
                fails++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, in_ready[0]);
            end
            if (busy[0] !== 1'b0) begin
                fails++; $display("FAIL hold_busy[%0d]: got %b want 0", i, busy[0]);
            end
        end
        in_valid[0] = 1'b0;
        release_out(0);
        checks += 2;
        if (out_valid[0] !== 1'b0) begin
            fails++; $display("FAIL release_out_valid: got %b want 0", out_valid[0]);
        end
        if (in_ready[0] !== 1'b1) begin
            fails++; $display("FAIL release_in_ready: got %b want 1", in_ready[0]);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
            fails++; $display("FAIL not_queued: got busy=%b out_valid=%b want 0 0", busy[0], out_valid[0]);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [M-1:0] zv;
        logic [M-1:0] av;
        logic [M-1:0] bv;
        int lat;
        bit seen;
        @(negedge clk);
        a = rand163();
        b = rand163();
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            fails++; $display("FAIL midop_busy: got %b want 1", busy[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (out_valid[0] !== 1'b0) begin
            fails++; $display("FAIL midop_out_valid: got %b want 0", out_valid[0]);
        end
        if (in_ready[0] !== 1'b1) begin
            fails++; $display("FAIL midop_in_ready: got %b want 1", in_ready[0]);
        end
        if (z[0] !== '0) begin
            fails++; $display("FAIL midop_z: got %h want 0", z[0]);
        end
        if (busy[0] !== 1'b0) begin
            fails++; $display("FAIL midop_busy_after: got %b want 0", busy[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            fails++; $display("FAIL midop_discard: got out_valid=1 want 0");
        end
        av = rand163();
        bv = rand163();
        do_op(0, av, bv, 1'b0, zv, lat);
        checks += 2;
        if (zv !== ref_mul(av, bv)) begin
            fails++; $display("FAIL after_reset_z: got %h want %h", zv, ref_mul(av, bv));
        end
        if (lat != 41) begin
            fails++; $display("FAIL after_reset_latency: got %0d want 41", lat);
        end
        release_out(0);
    endtask

    // Continuous in_valid and out_ready: accepts must land exactly N+2 cycles apart.
    task automatic test_back_to_back(input int k, input int nops);
        logic [M-1:0] q [$];
        logic [M-1:0] expz;
        int acc_n;
        int ret_n;
        int cyc;
        int last_acc;
        acc_n = 0;
        ret_n = 0;
        cyc = 0;
        last_acc = 0;
        sq = 1'b0;
        out_ready[k] = 1'b1;
        while (ret_n < nops && cyc < nops * (NS[k] + 2) + 50) begin
            @(negedge clk);
            cyc++;
            if (out_valid[k] === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL b2b_spurious[%0d]: got out_valid=1 want no result pending", k);
                end else begin
                    expz = q.pop_front();
                    if (z[k] !== expz) begin
                        fails++; $display("FAIL b2b_z[%0d] op %0d: got %h want %h", k, ret_n, z[k], expz);
                    end
                end
                ret_n++;
            end
            a = rand163();
            b = rand163();
            in_valid[k] = (acc_n < nops);
            if (in_valid[k] && in_ready[k] === 1'b1) begin
                q.push_back(ref_mul(a, b));
                if (acc_n > 0) begin
                    checks++;
                    if (cyc - last_acc != NS[k] + 2) begin
                        fails++; $display("FAIL b2b_interval[%0d]: got %0d want %0d", k, cyc - last_acc, NS[k] + 2);
                    end
                end
                last_acc = cyc;
                acc_n++;
            end
        end
        in_valid[k] = 1'b0;
        @(negedge clk);
        out_ready[k] = 1'b0;
        checks++;
        if (ret_n != nops) begin
            fails++; $display("FAIL b2b_count[%0d]: got %0d results want %0d", k, ret_n, nops);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_reduction();
        test_small_and_square();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back(4, 300);
        test_back_to_back(3, 300);
        test_back_to_back(0, 300);
        test_back_to_back(1, 60);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
